uart_tx_arbiter: RTL and testbench

Two-requester arbiter that shares the single 115200-baud `uart_tx` transmitter between the CPU TX data register path (requester 0) and a hardware byte source such as a debug/monitor engine (requester 1). It accepts bytes over per-requester valid/ready handshakes and selects between requesters round-robin. It holds exactly one byte in an output register and presents that byte to `uart_tx` over its `tx_data`/`tx_data_valid`/`tx_data_ready` handshake. Optional packet locking keeps a multi-byte message from one requester contiguous on the line.

---
 rtl/uart_tx_arbiter.sv | 148 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between two byte requesters via a one-byte output register.
// Define UART_ARB_LOCK_EN to keep multi-byte packets contiguous, with an idle-timeout lock release.
module uart_tx_arbiter #(
    parameter logic [15:0] LOCK_TIMEOUT = 16'd50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req0_data,
    input  logic       req0_valid,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic [7:0] req1_data,
    input  logic       req1_valid,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [1:0] owner,
    output logic       busy
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSend = 2'd1,
        StLock = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_valid_q, tx_valid_d;
    logic [1:0] owner_q, owner_d;
    logic       prio_q, prio_d;  // 1: requester 1 wins a tie
    logic       grant0, grant1;

`ifdef UART_ARB_LOCK_EN
    logic        last_q, last_d;
    logic [15:0] cnt_q, cnt_d;
`else
    logic unused_lock;
    assign unused_lock = ^{req0_last, req1_last, LOCK_TIMEOUT};
`endif

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == StIdle) begin
            if (req0_valid && req1_valid) begin
                grant0 = ~prio_q;
                grant1 = prio_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
`ifdef UART_ARB_LOCK_EN
        else if (state_q == StLock) begin
            grant0 = owner_q[0] && req0_valid;
            grant1 = owner_q[1] && req1_valid;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        owner_d    = owner_q;
        prio_d     = prio_q;
`ifdef UART_ARB_LOCK_EN
        last_d     = last_q;
        cnt_d      = cnt_q;
`endif
        unique case (state_q)
            StIdle, StLock: begin
                if (grant0 || grant1) begin
                    tx_data_d  = grant1 ? req1_data : req0_data;
                    tx_valid_d = 1'b1;
                    owner_d    = {grant1, grant0};
                    state_d    = StSend;
`ifdef UART_ARB_LOCK_EN
                    last_d     = grant1 ? req1_last : req0_last;
                    cnt_d      = '0;
                end else if (state_q == StLock) begin
                    // Owner went quiet: give up the lock so the other side is not starved.
                    if (cnt_q + 16'd1 == LOCK_TIMEOUT) begin
                        state_d = StIdle;
                        prio_d  = owner_q[0];
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
`endif
                end
            end
            StSend: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
`ifdef UART_ARB_LOCK_EN
                    if (last_q) begin
                        state_d = StIdle;
                        prio_d  = owner_q[0];
                    end else begin
                        state_d = StLock;
                        cnt_d   = '0;
                    end
`else
                    state_d = StIdle;
                    prio_d  = owner_q[0];
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            owner_q    <= 2'b00;
            prio_q     <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            last_q     <= 1'b0;
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            owner_q    <= owner_d;
            prio_q     <= prio_d;
`ifdef UART_ARB_LOCK_EN
            last_q     <= last_d;
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign owner      = owner_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a per-cycle vector table plus multi-cycle sequences.
// Lock-mode sequences are compiled in only when UART_ARB_LOCK_EN is defined.
module tb_uart_tx_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req0_data, req1_data;
    logic       req0_valid, req1_valid, req0_last, req1_last;
    logic       req0_ready, req1_ready;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [1:0] owner;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [8:0] src0[$];
    logic [8:0] src1[$];
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    uart_tx_arbiter #(.LOCK_TIMEOUT(16'd16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_data (req0_data),
        .req0_valid(req0_valid),
        .req0_last (req0_last),
        .req0_ready(req0_ready),
        .req1_data (req1_data),
        .req1_valid(req1_valid),
        .req1_last (req1_last),
        .req1_ready(req1_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .owner     (owner),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got=timeout want=finish");
        $fatal(1);
    end

    typedef struct {
        logic        v0;
        logic [7:0]  d0;
        logic        v1;
        logic [7:0]  d1;
        logic        txr;
        logic [13:0] expv;  // {req0_ready, req1_ready, tx_valid, tx_data, owner, busy}
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(logic v0, logic [7:0] d0, logic v1, logic [7:0] d1, logic txr,
                                logic r0, logic r1, logic tv, logic [7:0] td, logic [1:0] own,
                                logic bsy);
        vec_t v;
        v.v0   = v0;
        v.d0   = d0;
        v.v1   = v1;
        v.d1   = d1;
        v.txr  = txr;
        v.expv = {r0, r1, tv, td, own, bsy};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got=%0h want=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req0_data  = 8'h00;
        req0_last  = 1'b1;
        req1_valid = 1'b0;
        req1_data  = 8'h00;
        req1_last  = 1'b1;
        tx_ready   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        check("reset_values", {18'd0, req0_ready, req1_ready, tx_valid, tx_data, owner, busy},
              32'd0);
        rst_n = 1'b1;
    endtask

    // Requesters present queued bytes and advance only on acceptance; gate0 holds
    // requester 0 off until requester 1 has had its first byte accepted.
    task automatic run_stream(input bit gate0, input int max_cyc);
        int   i0 = 0;
        int   i1 = 0;
        bit   seen1 = 0;
        logic a0, a1, x;
        logic [7:0] xd;
        got.delete();
        for (int c = 0; c < max_cyc; c++) begin
            req0_valid = (i0 < src0.size()) && (!gate0 || seen1);
            req0_data  = (i0 < src0.size()) ? src0[i0][7:0] : 8'h00;
            req0_last  = (i0 < src0.size()) ? src0[i0][8] : 1'b1;
            req1_valid = (i1 < src1.size());
            req1_data  = (i1 < src1.size()) ? src1[i1][7:0] : 8'h00;
            req1_last  = (i1 < src1.size()) ? src1[i1][8] : 1'b1;
            tx_ready   = 1'b1;
            @(negedge clk);
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            x  = tx_valid && tx_ready;
            xd = tx_data;
            tick();
            if (a0) i0++;
            if (a1) begin
                i1++;
                seen1 = 1'b1;
            end
            if (x) got.push_back(xd);
            if (got.size() == src0.size() + src1.size()) break;
        end
        idle_inputs();
        check("stream_len", got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            check($sformatf("stream_byte%0d", i), {24'd0, got[i]}, {24'd0, exp_q[i]});
        end
    endtask

    initial begin
        int   xfers;
        int   lock_cyc;
        logic acc;
        logic bsy_at;

        vecs[0]  = mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 0, 8'h00, 2'b00, 0);
        vecs[1]  = mk(1, 8'h41, 0, 8'h00, 1,  1, 0, 0, 8'h00, 2'b00, 0);
        vecs[2]  = mk(0, 8'h00, 0, 8'h00, 1,  0, 0, 1, 8'h41, 2'b01, 1);
        vecs[3]  = mk(0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 8'h41, 2'b01, 0);
        vecs[4]  = mk(1, 8'h30, 1, 8'h60, 0,  0, 1, 0, 8'h41, 2'b01, 0);
        vecs[5]  = mk(1, 8'h30, 1, 8'h61, 0,  0, 0, 1, 8'h60, 2'b10, 1);
        vecs[6]  = mk(1, 8'h30, 1, 8'h61, 1,  0, 0, 1, 8'h60, 2'b10, 1);
        vecs[7]  = mk(1, 8'h30, 1, 8'h61, 1,  1, 0, 0, 8'h60, 2'b10, 0);
        vecs[8]  = mk(0, 8'h00, 1, 8'h61, 1,  0, 0, 1, 8'h30, 2'b01, 1);
        vecs[9]  = mk(0, 8'h00, 1, 8'h61, 0,  0, 1, 0, 8'h30, 2'b01, 0);
        vecs[10] = mk(0, 8'h00, 0, 8'h00, 1,  0, 0, 1, 8'h61, 2'b10, 1);
        vecs[11] = mk(0, 8'h00, 1, 8'h62, 0,  0, 1, 0, 8'h61, 2'b10, 0);
        vecs[12] = mk(0, 8'h00, 0, 8'h00, 1,  0, 0, 1, 8'h62, 2'b10, 1);
        vecs[13] = mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 0, 8'h62, 2'b10, 0);

        do_reset();
        for (int i = 0; i < 14; i++) begin
            tick();
            req0_valid = vecs[i].v0;
            req0_data  = vecs[i].d0;
            req1_valid = vecs[i].v1;
            req1_data  = vecs[i].d1;
            tx_ready   = vecs[i].txr;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  {18'd0, req0_ready, req1_ready, tx_valid, tx_data, owner, busy},
                  {18'd0, vecs[i].expv});
        end
        tick();
        idle_inputs();

        // Downstream stall with other bytes waiting on both requesters.
        do_reset();
        tick();
        req0_valid = 1'b1;
        req0_data  = 8'h55;
        @(negedge clk);
        check("stall_accept", {31'd0, req0_ready}, 32'd1);
        tick();
        req0_data  = 8'h56;
        req1_valid = 1'b1;
        req1_data  = 8'h66;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check($sformatf("stall%0d", c), {20'd0, tx_valid, tx_data, req0_ready, req1_ready},
                  {20'd0, 1'b1, 8'h55, 1'b0, 1'b0});
            tick();
        end
        idle_inputs();
        tx_ready = 1'b1;
        xfers = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (tx_valid && tx_ready) xfers++;
            tick();
        end
        check("stall_xfers", xfers, 1);
        idle_inputs();

        // Both requesters continuously valid: strict alternation.
        do_reset();
        src0 = '{9'h130, 9'h131, 9'h132, 9'h133};
        src1 = '{9'h160, 9'h161, 9'h162, 9'h163};
        exp_q = '{8'h30, 8'h60, 8'h31, 8'h61, 8'h32, 8'h62, 8'h33, 8'h63};
        run_stream(1'b0, 100);

        // Asynchronous reset while a byte sits in the output register.
        do_reset();
        tick();
        req0_valid = 1'b1;
        req0_data  = 8'h5A;
        tick();
        req0_valid = 1'b0;
        #2;
        check("rst_pre_valid", {31'd0, tx_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async", {30'd0, tx_valid, busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        src0.delete();
        src1 = '{9'h17A};
        exp_q = '{8'h7A};
        run_stream(1'b0, 20);
        check("rst_owner", {30'd0, owner}, 32'd2);

`ifdef UART_ARB_LOCK_EN
        // Packet from requester 1 stays contiguous while requester 0 waits.
        do_reset();
        src0 = '{9'h130};
        src1 = '{9'h04F, 9'h04B, 9'h10A};
        exp_q = '{8'h4F, 8'h4B, 8'h0A, 8'h30};
        run_stream(1'b1, 100);

        // Lock abandoned by its owner is released after LOCK_TIMEOUT idle cycles.
        do_reset();
        tick();
        req1_valid = 1'b1;
        req1_data  = 8'h77;
        req1_last  = 1'b0;
        tx_ready   = 1'b1;
        @(negedge clk);
        check("lock_acc", {31'd0, req1_ready}, 32'd1);
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1;
        req0_data  = 8'h31;
        req0_last  = 1'b1;
        @(negedge clk);
        check("lock_send", {30'd0, tx_valid, req0_ready}, 32'd2);
        tick();
        lock_cyc = 0;
        acc      = 1'b0;
        bsy_at   = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (req0_ready) begin
                acc    = 1'b1;
                bsy_at = busy;
                break;
            end
            if (busy) lock_cyc++;
            tick();
        end
        check("lock_released", {31'd0, acc}, 32'd1);
        check("lock_cycles", lock_cyc, 16);
        check("lock_busy_drop", {31'd0, bsy_at}, 32'd0);
        tick();
        req0_valid = 1'b0;
        #1;
        check("lock_next_byte", {22'd0, tx_valid, tx_data, owner[0]}, {22'd0, 1'b1, 8'h31, 1'b1});
        idle_inputs();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
